// File: rtl/video_timing_pkg.sv
// Shared timing defaults and counter widths for the raster timing generator.
package video_timing_pkg;

  localparam int CNT_W      = 9;
  localparam int INT_CH_MAX = 8;

  localparam int D_H_TOTAL     = 384;
  localparam int D_V_TOTAL     = 312;
  localparam int D_H_BLANK_ON  = 28;
  localparam int D_H_SYNC_ON   = 44;
  localparam int D_H_SYNC_OFF  = 76;
  localparam int D_H_BLANK_OFF = 108;
  localparam int D_V_BLANK_ON  = 236;
  localparam int D_V_SYNC_ON   = 240;
  localparam int D_V_SYNC_OFF  = 244;
  localparam int D_V_BLANK_OFF = 260;
  localparam int D_H_ACT_START = 128;
  localparam int D_V_ACT       = 192;
  localparam int D_INT_CH      = 2;
  localparam int D_INT_START   = 4;
  localparam int D_INT_LEN     = 128;
  localparam int D_V_INT_LINE  = 244;
  localparam int D_FLASH_W     = 5;

endpackage

// File: rtl/int_channel.sv
// One interrupt source: compare register, fire detect, pulse or sticky output state.
module int_channel
  import video_timing_pkg::*;
#(
  parameter int STICKY      = 0,
  parameter int INT_START   = D_INT_START,
  parameter int INT_LEN     = D_INT_LEN,
  parameter int H_TOTAL     = D_H_TOTAL,
  parameter int V_ACT       = D_V_ACT,
  parameter bit RANGE_CHECK = 1'b1,
  parameter int CMP_INIT    = 511
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [CNT_W-1:0] hc,
  input  logic [CNT_W-1:0] vc,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             ack,
  output logic             irq
);

  localparam int               END_I   = INT_START + INT_LEN;
  localparam logic [CNT_W-1:0] START_C = CNT_W'(INT_START);
  localparam logic [CNT_W-1:0] END_C   = CNT_W'(END_I);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VACT_C  = CNT_W'(V_ACT);
  localparam bit               END_OK  = (END_I < H_TOTAL);

  logic [CNT_W-1:0] cmp;
  logic             in_range;
  logic             fire;
  logic             stop;

  // Compares beyond the active area are parked/disabled; the frame source opts out.
  assign in_range = !RANGE_CHECK || (cmp < VACT_C);
  assign fire     = ce_pix && (hc == START_C) && (vc == cmp) && in_range;
  assign stop     = ce_pix && ((END_OK && (hc == END_C)) || (hc == LAST_C));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)      cmp <= CNT_W'(CMP_INIT);
    else if (wr_en) cmp <= wr_data;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (fire) begin
      irq <= 1'b1;
    end else if (STICKY != 0) begin
      if (ack) irq <= 1'b0;
    end else if (stop) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: rtl/raster_timing_gen.sv
// Raster counters, blank/sync strobes, active window, flash phase, line/frame interrupts and light pen.
module raster_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL     = D_H_TOTAL,
  parameter int V_TOTAL     = D_V_TOTAL,
  parameter int H_BLANK_ON  = D_H_BLANK_ON,
  parameter int H_SYNC_ON   = D_H_SYNC_ON,
  parameter int H_SYNC_OFF  = D_H_SYNC_OFF,
  parameter int H_BLANK_OFF = D_H_BLANK_OFF,
  parameter int V_BLANK_ON  = D_V_BLANK_ON,
  parameter int V_SYNC_ON   = D_V_SYNC_ON,
  parameter int V_SYNC_OFF  = D_V_SYNC_OFF,
  parameter int V_BLANK_OFF = D_V_BLANK_OFF,
  parameter int H_ACT_START = D_H_ACT_START,
  parameter int V_ACT       = D_V_ACT,
  parameter int INT_CH      = D_INT_CH,
  parameter int INT_START   = D_INT_START,
  parameter int INT_LEN     = D_INT_LEN,
  parameter int V_INT_LINE  = D_V_INT_LINE,
  parameter int STICKY      = 0,
  parameter int FLASH_W     = D_FLASH_W
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [8:0]        wr_data,
  input  logic [INT_CH:0]   int_ack,
  input  logic              lpen_strobe,
  output logic [8:0]        hc,
  output logic [8:0]        vc,
  output logic              hblank,
  output logic              hsync,
  output logic              vblank,
  output logic              vsync,
  output logic              active,
  output logic              flash,
  output logic [INT_CH-1:0] int_line,
  output logic              int_frame,
  output logic [7:0]        lpen_h,
  output logic [7:0]        lpen_v
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HB_ON   = CNT_W'(H_BLANK_ON);
  localparam logic [CNT_W-1:0] HB_OFF  = CNT_W'(H_BLANK_OFF);
  localparam logic [CNT_W-1:0] HS_ON   = CNT_W'(H_SYNC_ON);
  localparam logic [CNT_W-1:0] HS_OFF  = CNT_W'(H_SYNC_OFF);
  localparam logic [CNT_W-1:0] VB_ON   = CNT_W'(V_BLANK_ON);
  localparam logic [CNT_W-1:0] VB_OFF  = CNT_W'(V_BLANK_OFF);
  localparam logic [CNT_W-1:0] VS_ON   = CNT_W'(V_SYNC_ON);
  localparam logic [CNT_W-1:0] VS_OFF  = CNT_W'(V_SYNC_OFF);
  localparam logic [CNT_W-1:0] HA_C    = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0] VA_C    = CNT_W'(V_ACT);
  localparam logic [7:0]       VA_LO   = 8'(V_ACT);

  logic               hc_wrap;
  logic               vc_wrap;
  logic               in_window;
  logic [7:0]         hc_rel;
  logic [FLASH_W-1:0] flash_cnt;

  assign hc_wrap   = (hc == H_LAST);
  assign vc_wrap   = (vc == V_LAST);
  assign in_window = (hc >= HA_C) && (vc < VA_C);
  assign hc_rel    = 8'(hc - HA_C);
  assign flash     = flash_cnt[FLASH_W-1];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hc        <= '0;
      vc        <= '0;
      flash_cnt <= '0;
    end else if (ce_pix) begin
      hc <= hc_wrap ? '0 : hc + 1'b1;
      if (hc_wrap) begin
        vc <= vc_wrap ? '0 : vc + 1'b1;
        if (vc_wrap) flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end

  // Strobes are decoded from the current count, so they trail hc/vc by one pixel.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hblank <= 1'b0;
      hsync  <= 1'b0;
      vblank <= 1'b0;
      vsync  <= 1'b0;
      active <= 1'b0;
      lpen_h <= '0;
      lpen_v <= '0;
    end else if (ce_pix) begin
      if (hc == HB_ON)       hblank <= 1'b1;
      else if (hc == HB_OFF) hblank <= 1'b0;
      if (hc == HS_ON)       hsync  <= 1'b1;
      else if (hc == HS_OFF) hsync  <= 1'b0;
      if (hc == '0) begin
        if (vc == VS_ON)       vsync <= 1'b1;
        else if (vc == VS_OFF) vsync <= 1'b0;
      end
      if (hc == HB_ON) begin
        if (vc == VB_ON)       vblank <= 1'b1;
        else if (vc == VB_OFF) vblank <= 1'b0;
      end
      active <= in_window;
      if (lpen_strobe) begin
        lpen_h <= in_window ? hc_rel : 8'd0;
        lpen_v <= in_window ? vc[7:0] : VA_LO;
      end
    end
  end

  for (genvar i = 0; i < INT_CH; i++) begin : g_line
    int_channel #(
      .STICKY(STICKY), .INT_START(INT_START), .INT_LEN(INT_LEN),
      .H_TOTAL(H_TOTAL), .V_ACT(V_ACT), .RANGE_CHECK(1'b1), .CMP_INIT(511)
    ) u_ch (
      .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hc(hc), .vc(vc),
      .wr_en(wr_en && (wr_sel == 3'(i))), .wr_data(wr_data),
      .ack(int_ack[i]), .irq(int_line[i])
    );
  end

  int_channel #(
    .STICKY(STICKY), .INT_START(INT_START), .INT_LEN(INT_LEN),
    .H_TOTAL(H_TOTAL), .V_ACT(V_ACT), .RANGE_CHECK(1'b0), .CMP_INIT(V_INT_LINE)
  ) u_frame (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hc(hc), .vc(vc),
    .wr_en(1'b0), .wr_data('0),
    .ack(int_ack[INT_CH]), .irq(int_frame)
  );

endmodule

// File: doc/raster_timing_gen.md
# raster_timing_gen

Parametrised raster timing and interrupt generator for the video subsystem. It produces horizontal and vertical counters, blank and sync strobes, an active-display window and a flash phase. It provides N independently programmable line-interrupt channels plus a frame interrupt, each with selectable pulse or sticky-with-acknowledge behaviour, and a light-pen position latch. It sits between the pixel clock-enable generator and the pixel fetch/palette stage, and replaces hard-coded 384×312 counting in the mode-specific video logic.

## Interface
- H_TOTAL, 384: pixel clocks per line.
- V_TOTAL, 312: lines per frame.
- H_BLANK_ON / H_SYNC_ON / H_SYNC_OFF / H_BLANK_OFF, 28 / 44 / 76 / 108: hc values at which the strobe changes.
- V_BLANK_ON / V_SYNC_ON / V_SYNC_OFF / V_BLANK_OFF, 236 / 240 / 244 / 260: vc values; vsync changes at hc==0, vblank changes at hc==H_BLANK_ON.
- H_ACT_START, 128: first active pixel.
- V_ACT, 192: active lines (0..V_ACT-1).
- INT_CH, 2: line-interrupt channels, range 1..8.
- INT_START, 4: hc at which interrupts fire.
- INT_LEN, 128: pulse width in pixel clocks; range 1..H_TOTAL-1.
- V_INT_LINE, 244: frame-interrupt line.
- STICKY, 0: 1 makes every interrupt a level held until acknowledged.
- FLASH_W, 5: flash counter width.

Ports:
- clk_sys  in  1  master clock.
- reset  in  1  asynchronous, active-high.
- ce_pix  in  1  pixel clock enable; all state advances only on this enable.
- wr_en  in  1  single-cycle register write strobe.
- wr_sel  in  3  channel index; values ≥ INT_CH are ignored.
- wr_data  in  9  compare line.
- int_ack  in  INT_CH+1  per-source acknowledge; bit INT_CH is the frame interrupt.
- lpen_strobe  in  1  light-pen capture request.
- hc  out  9  horizontal counter.
- vc  out  9  vertical counter.
- hblank, hsync, vblank, vsync  out  1 each  registered strobes.
- active  out  1  asserted when hc ≥ H_ACT_START and vc < V_ACT.
- flash  out  1  MSB of the flash counter.
- int_line  out  INT_CH  line interrupts.
- int_frame  out  1  frame interrupt.
- lpen_h  out  8  captured horizontal position.
- lpen_v  out  8  captured vertical position.

## Operation
- Reset values: every output 0; all compare registers 9'h1FF (disabled); flash counter 0.
- Counters, on ce_pix:
  - hc wraps H_TOTAL-1 → 0; otherwise it increments.
  - vc increments on hc wrap and wraps V_TOTAL-1 → 0.
  - The flash counter increments on frame wrap, modulo 2^FLASH_W.
- Strobes, on ce_pix: each is set or cleared in the cycle its counter equals the listed value.
- Compare registers: a write stores wr_data into cmp[wr_sel] on the wr_en cycle, independent of ce_pix. A compare value ≥ V_ACT never fires.
- Interrupt fire condition, on ce_pix: hc==INT_START and vc==cmp[i]. The frame interrupt uses vc==V_INT_LINE.
- STICKY=0: the output asserts on fire and deasserts at hc==INT_START+INT_LEN on the same line, or at hc wrap if that comes first. int_ack is ignored.
- STICKY=1: the output holds until int_ack[i] is sampled high on any clk_sys edge. If ack and fire coincide, fire wins.
- A compare write that lands on the firing cycle takes effect from the next fire check.
- Light pen: on lpen_strobe with ce_pix:
  - In the active window: lpen_h ← (hc − H_ACT_START)[7:0], lpen_v ← vc[7:0].
  - Otherwise: lpen_h ← 0, lpen_v ← V_ACT[7:0].

## Timing
- All outputs are registered; strobes and interrupts appear one clk_sys edge after the ce_pix edge on which the condition is met.
- hc and vc are visible on the same edge they update.
- The interrupt-to-pixel relationship is exact: the rising edge of int_line follows hc becoming INT_START.
- Reset asserted mid-frame clears everything immediately, asynchronously. Counting restarts at hc=vc=0 on the first ce_pix after release.
- Two channels with the same compare value fire simultaneously.

## Structure
- Package video_timing_pkg holds:
  - default timing localparams;
  - the INT_CH upper limit (8);
  - the counter width constant (9).
- Sub-module int_channel contains one compare register, the fire logic and the pulse/sticky state. It is instantiated INT_CH times via generate; the frame interrupt uses a fixed-compare instance.

## Test plan
- Free-run with defaults → hc wraps at 383, vc at 311; one frame is 119808 ce_pix; flash toggles every 16 frames.
- Write cmp[1]=100 with STICKY=0 → int_line[1] rises after hc=4 on vc=100, falls after hc=132, and is quiet on other lines.
- STICKY=1, cmp[0]=50, no ack → int_line[0] holds across lines. Ack at vc=60 clears it. Ack coinciding with a refire keeps it high.
- cmp=200 (≥ V_ACT) → no line interrupt. int_frame fires at vc=244, hc=4.
- lpen_strobe at vc=10, hc=200 → lpen_h=72, lpen_v=10. At vc=250 → lpen_h=0, lpen_v=192.
- Reset pulse mid-line at vc=120, hc=300 while int_line[1] is high → all outputs 0 at once; the next ce_pix after release gives hc=1.
